// File: rtl/vernam_decipher.sv
`timescale 1ns/1ps
// Vernam one-time-pad decrypt engine: XORs host ciphertext bytes with pad bytes
// from a key FIFO and queues plaintext for the host PicoBlaze, with a set/ack interrupt.
//
// state   | meaning
// IDLE    | no ciphertext held, ready to accept a host write
// HAVE_CT | ciphertext latched, waiting for a pad byte and output space
module vernam_decipher #(
  parameter int          KEY_DEPTH   = 4,
  parameter int          OUT_DEPTH   = 4,
  parameter logic [7:0]  CT_PORT     = 8'h01,
  parameter logic [7:0]  PT_PORT     = 8'h02,
  parameter logic [7:0]  STATUS_PORT = 8'h04
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] port_id,
  input  logic       write_strobe,
  input  logic       read_strobe,
  input  logic [7:0] out_port,
  output logic [7:0] in_port,
  output logic       interrupt,
  input  logic       interrupt_ack,
  input  logic       key_strobe,
  input  logic [7:0] key_data,
  output logic       key_request
);

  localparam int KPW = $clog2(KEY_DEPTH);
  localparam int KCW = KPW + 1;
  localparam int OPW = $clog2(OUT_DEPTH);
  localparam int OCW = OPW + 1;
  localparam logic [KCW-1:0] KEY_FULL_CNT = KCW'(KEY_DEPTH);
  localparam logic [OCW-1:0] OUT_FULL_CNT = OCW'(OUT_DEPTH);

  typedef enum logic {IDLE, HAVE_CT} state_e;

  state_e           state_q, state_d;
  logic [7:0]       ct_q, ct_d;
  logic [7:0]       key_mem_q [KEY_DEPTH];
  logic [7:0]       key_mem_d [KEY_DEPTH];
  logic [KPW-1:0]   key_wr_q, key_wr_d, key_rd_q, key_rd_d;
  logic [KCW-1:0]   key_cnt_q, key_cnt_d;
  logic [7:0]       out_mem_q [OUT_DEPTH];
  logic [7:0]       out_mem_d [OUT_DEPTH];
  logic [OPW-1:0]   out_wr_q, out_wr_d, out_rd_q, out_rd_d;
  logic [OCW-1:0]   out_cnt_q, out_cnt_d;
  logic             key_ovf_q, key_ovf_d;
  logic             ct_ovr_q, ct_ovr_d;
  logic             irq_q, irq_d;

  logic key_full, key_empty, out_full, out_empty, busy;
  logic ct_wr, pt_rd, st_rd, decrypt, key_push, key_drop, ct_drop;
  logic [7:0] status;

  assign key_full  = (key_cnt_q == KEY_FULL_CNT);
  assign key_empty = (key_cnt_q == '0);
  assign out_full  = (out_cnt_q == OUT_FULL_CNT);
  assign out_empty = (out_cnt_q == '0);
  assign busy      = (state_q == HAVE_CT);

  assign ct_wr   = write_strobe && (port_id == CT_PORT);
  assign pt_rd   = read_strobe && (port_id == PT_PORT) && !out_empty;
  assign st_rd   = read_strobe && (port_id == STATUS_PORT);
  // A host read on the same edge frees a slot, so a full output FIFO need not stall.
  assign decrypt  = busy && !key_empty && (!out_full || pt_rd);
  assign key_push = key_strobe && (!key_full || decrypt);
  assign key_drop = key_strobe && !key_push;
  assign ct_drop  = ct_wr && busy;

  assign status      = {2'b00, ct_ovr_q, key_ovf_q, busy, key_empty, out_full, !out_empty};
  assign interrupt   = irq_q;
  assign key_request = !key_full;

  always_comb begin
    in_port = 8'h00;
    if (port_id == PT_PORT) begin
      if (!out_empty) in_port = out_mem_q[out_rd_q];
    end else if (port_id == STATUS_PORT) begin
      in_port = status;
    end
  end

  always_comb begin
    state_d   = state_q;
    ct_d      = ct_q;
    key_mem_d = key_mem_q;
    key_wr_d  = key_wr_q;
    key_rd_d  = key_rd_q;
    key_cnt_d = key_cnt_q;
    out_mem_d = out_mem_q;
    out_wr_d  = out_wr_q;
    out_rd_d  = out_rd_q;
    out_cnt_d = out_cnt_q;
    key_ovf_d = key_ovf_q;
    ct_ovr_d  = ct_ovr_q;
    irq_d     = irq_q;

    case (state_q)
      IDLE: begin
        if (ct_wr) begin
          ct_d    = out_port;
          state_d = HAVE_CT;
        end
      end
      HAVE_CT: begin
        if (decrypt) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (key_push) begin
      key_mem_d[key_wr_q] = key_data;
      key_wr_d            = key_wr_q + 1'b1;
    end
    if (decrypt) key_rd_d = key_rd_q + 1'b1;
    case ({key_push, decrypt})
      2'b10:   key_cnt_d = key_cnt_q + 1'b1;
      2'b01:   key_cnt_d = key_cnt_q - 1'b1;
      default: key_cnt_d = key_cnt_q;
    endcase

    if (decrypt) begin
      out_mem_d[out_wr_q] = ct_q ^ key_mem_q[key_rd_q];
      out_wr_d            = out_wr_q + 1'b1;
    end
    if (pt_rd) out_rd_d = out_rd_q + 1'b1;
    case ({decrypt, pt_rd})
      2'b10:   out_cnt_d = out_cnt_q + 1'b1;
      2'b01:   out_cnt_d = out_cnt_q - 1'b1;
      default: out_cnt_d = out_cnt_q;
    endcase

    // An overflow on the clearing edge must survive the status read.
    if (st_rd) begin
      key_ovf_d = 1'b0;
      ct_ovr_d  = 1'b0;
    end
    if (key_drop) key_ovf_d = 1'b1;
    if (ct_drop)  ct_ovr_d  = 1'b1;

    if (interrupt_ack) irq_d = 1'b0;
    if (decrypt)       irq_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      ct_q      <= 8'h00;
      key_wr_q  <= '0;
      key_rd_q  <= '0;
      key_cnt_q <= '0;
      out_wr_q  <= '0;
      out_rd_q  <= '0;
      out_cnt_q <= '0;
      key_ovf_q <= 1'b0;
      ct_ovr_q  <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ct_q      <= ct_d;
      key_wr_q  <= key_wr_d;
      key_rd_q  <= key_rd_d;
      key_cnt_q <= key_cnt_d;
      out_wr_q  <= out_wr_d;
      out_rd_q  <= out_rd_d;
      out_cnt_q <= out_cnt_d;
      key_ovf_q <= key_ovf_d;
      ct_ovr_q  <= ct_ovr_d;
      irq_q     <= irq_d;
    end
  end

  // Storage arrays carry no reset; the counts alone define validity.
  always_ff @(posedge clk) begin
    key_mem_q <= key_mem_d;
    out_mem_q <= out_mem_d;
  end

endmodule

// File: tb/tb_vernam_decipher.sv
`timescale 1ns/1ps
// Directed self-checking bench for vernam_decipher.
module tb_vernam_decipher;

  localparam logic [7:0] CT = 8'h01, PT = 8'h02, ST = 8'h04;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] port_id = 8'h00;
  logic       write_strobe = 1'b0;
  logic       read_strobe = 1'b0;
  logic [7:0] out_port = 8'h00;
  logic [7:0] in_port;
  logic       interrupt;
  logic       interrupt_ack = 1'b0;
  logic       key_strobe = 1'b0;
  logic [7:0] key_data = 8'h00;
  logic       key_request;

  int checks = 0;
  int errors = 0;

  vernam_decipher dut (
    .clk(clk), .reset(reset), .port_id(port_id), .write_strobe(write_strobe),
    .read_strobe(read_strobe), .out_port(out_port), .in_port(in_port),
    .interrupt(interrupt), .interrupt_ack(interrupt_ack), .key_strobe(key_strobe),
    .key_data(key_data), .key_request(key_request)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    port_id = 8'h00; write_strobe = 0; read_strobe = 0; interrupt_ack = 0; key_strobe = 0;
    reset = 1;
    tick();
    reset = 0;
  endtask

  task automatic push_key(input logic [7:0] b);
    key_strobe = 1; key_data = b;
    tick();
    key_strobe = 0;
  endtask

  task automatic write_ct(input logic [7:0] b);
    port_id = CT; write_strobe = 1; out_port = b;
    tick();
    write_strobe = 0; port_id = 8'h00;
  endtask

  task automatic peek(input logic [7:0] p, output logic [7:0] v);
    port_id = p;
    #1;
    v = in_port;
  endtask

  task automatic read_port(input logic [7:0] p, output logic [7:0] v);
    port_id = p;
    #1;
    v = in_port;
    read_strobe = 1;
    tick();
    read_strobe = 0; port_id = 8'h00;
  endtask

  task automatic ack();
    interrupt_ack = 1;
    tick();
    interrupt_ack = 0;
  endtask

  task automatic test_reset();
    logic [7:0] v;
    do_reset();
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL reset_irq got %b exp 0", interrupt); end
    checks++; if (key_request !== 1'b1) begin errors++; $display("FAIL reset_keyreq got %b exp 1", key_request); end
    peek(ST, v);
    checks++; if (v !== 8'h04) begin errors++; $display("FAIL reset_status got %h exp 04", v); end
    peek(PT, v);
    checks++; if (v !== 8'h00) begin errors++; $display("FAIL reset_pt_empty got %h exp 00", v); end
    peek(8'h80, v);
    checks++; if (v !== 8'h00) begin errors++; $display("FAIL other_port got %h exp 00", v); end
  endtask

  task automatic test_decrypt_key_present();
    logic [7:0] v;
    do_reset();
    push_key(8'h5A);
    write_ct(8'h3C);
    peek(ST, v);
    checks++; if (v !== 8'h08) begin errors++; $display("FAIL kp_busy_status got %h exp 08", v); end
    tick();
    checks++; if (interrupt !== 1'b1) begin errors++; $display("FAIL kp_irq got %b exp 1", interrupt); end
    peek(ST, v);
    checks++; if (v !== 8'h05) begin errors++; $display("FAIL kp_status got %h exp 05", v); end
    read_port(PT, v);
    checks++; if (v !== 8'h66) begin errors++; $display("FAIL kp_plain got %h exp 66", v); end
    peek(ST, v);
    checks++; if (v !== 8'h04) begin errors++; $display("FAIL kp_status_after_read got %h exp 04", v); end
    checks++; if (interrupt !== 1'b1) begin errors++; $display("FAIL kp_irq_sticky got %b exp 1", interrupt); end
    ack();
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL kp_ack got %b exp 0", interrupt); end
  endtask

  task automatic test_ct_before_key();
    logic [7:0] v;
    do_reset();
    write_ct(8'hFF);
    tick(); tick();
    peek(ST, v);
    checks++; if (v !== 8'h0C) begin errors++; $display("FAIL cbk_wait_status got %h exp 0C", v); end
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL cbk_no_irq got %b exp 0", interrupt); end
    push_key(8'h0F);
    peek(ST, v);
    checks++; if (v !== 8'h08) begin errors++; $display("FAIL cbk_edge_k_status got %h exp 08", v); end
    tick();
    peek(ST, v);
    checks++; if (v !== 8'h05) begin errors++; $display("FAIL cbk_k1_status got %h exp 05", v); end
    read_port(PT, v);
    checks++; if (v !== 8'hF0) begin errors++; $display("FAIL cbk_plain got %h exp F0", v); end
  endtask

  task automatic test_key_overflow();
    logic [7:0] v;
    logic [7:0] exp;
    do_reset();
    for (int i = 1; i <= 4; i++) push_key(8'(i));
    checks++; if (key_request !== 1'b0) begin errors++; $display("FAIL ovf_keyreq_full got %b exp 0", key_request); end
    peek(ST, v);
    checks++; if (v !== 8'h00) begin errors++; $display("FAIL ovf_status_full got %h exp 00", v); end
    push_key(8'h05);
    read_port(ST, v);
    checks++; if (v !== 8'h10) begin errors++; $display("FAIL ovf_status_flag got %h exp 10", v); end
    peek(ST, v);
    checks++; if (v !== 8'h00) begin errors++; $display("FAIL ovf_status_cleared got %h exp 00", v); end
    for (int i = 1; i <= 4; i++) begin
      write_ct(8'h00);
      tick();
      if (i == 1) begin
        checks++; if (key_request !== 1'b1) begin errors++; $display("FAIL ovf_keyreq_after_pop got %b exp 1", key_request); end
      end
      exp = 8'(i);
      read_port(PT, v);
      checks++; if (v !== exp) begin errors++; $display("FAIL ovf_key_order got %h exp %h", v, exp); end
    end
  endtask

  task automatic test_out_full_stall();
    logic [7:0] v;
    logic [7:0] exp;
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      push_key(8'(i * 16));
      write_ct(8'(i * 17));
      tick();
    end
    push_key(8'h50);
    write_ct(8'h55);
    tick();
    peek(ST, v);
    checks++; if (v !== 8'h0B) begin errors++; $display("FAIL full_stall_status got %h exp 0B", v); end
    read_port(PT, v);
    checks++; if (v !== 8'h01) begin errors++; $display("FAIL full_first got %h exp 01", v); end
    peek(ST, v);
    checks++; if (v !== 8'h07) begin errors++; $display("FAIL full_push_on_read got %h exp 07", v); end
    for (int i = 2; i <= 5; i++) begin
      exp = 8'(i);
      read_port(PT, v);
      checks++; if (v !== exp) begin errors++; $display("FAIL full_drain got %h exp %h", v, exp); end
    end
    peek(ST, v);
    checks++; if (v !== 8'h04) begin errors++; $display("FAIL full_drained_status got %h exp 04", v); end
  endtask

  task automatic test_ct_overrun_ack();
    logic [7:0] v;
    do_reset();
    write_ct(8'hAA);
    write_ct(8'hBB);
    peek(ST, v);
    checks++; if (v !== 8'h2C) begin errors++; $display("FAIL ovr_status got %h exp 2C", v); end
    push_key(8'h55);
    ack();
    checks++; if (interrupt !== 1'b1) begin errors++; $display("FAIL ovr_ack_race got %b exp 1", interrupt); end
    read_port(ST, v);
    checks++; if (v !== 8'h25) begin errors++; $display("FAIL ovr_status_after got %h exp 25", v); end
    read_port(PT, v);
    checks++; if (v !== 8'hFF) begin errors++; $display("FAIL ovr_plain got %h exp FF", v); end
    peek(ST, v);
    checks++; if (v !== 8'h04) begin errors++; $display("FAIL ovr_cleared got %h exp 04", v); end
    ack();
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL ovr_late_ack got %b exp 0", interrupt); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] v;
    do_reset();
    push_key(8'h11);
    write_ct(8'h22);
    tick();
    push_key(8'hA1);
    key_strobe = 1; key_data = 8'hA2;
    port_id = CT; write_strobe = 1; out_port = 8'hC3;
    tick();
    key_strobe = 0; write_strobe = 0; port_id = 8'h00;
    peek(ST, v);
    checks++; if (v !== 8'h09) begin errors++; $display("FAIL mid_pre_status got %h exp 09", v); end
    do_reset();
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL mid_irq got %b exp 0", interrupt); end
    checks++; if (key_request !== 1'b1) begin errors++; $display("FAIL mid_keyreq got %b exp 1", key_request); end
    peek(ST, v);
    checks++; if (v !== 8'h04) begin errors++; $display("FAIL mid_status got %h exp 04", v); end
    tick(); tick(); tick();
    peek(ST, v);
    checks++; if (v !== 8'h04) begin errors++; $display("FAIL mid_no_output got %h exp 04", v); end
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL mid_irq_later got %b exp 0", interrupt); end
  endtask

  initial begin
    test_reset();
    test_decrypt_key_present();
    test_ct_before_key();
    test_key_overflow();
    test_out_full_stall();
    test_ct_overrun_ack();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vernam_decipher.md
Name: vernam_decipher

Overview:
- Hardware decrypt end of the Vernam one-time-pad link. The cipher engine encrypts on the transmit side; this block reverses it.
- A host PicoBlaze writes ciphertext bytes over its port bus. A key-source PicoBlaze streams pad bytes into a key FIFO.
- The block XORs each ciphertext byte with the next pad byte and queues the plaintext in an output FIFO.
- It notifies the host through a set/ack interrupt flag.

Parameters:
KEY_DEPTH, 4, key FIFO entries (power of two, >=2)
OUT_DEPTH, 4, plaintext FIFO entries (power of two, >=2)
CT_PORT, 8'h01, host port_id for ciphertext writes
PT_PORT, 8'h02, host port_id for plaintext reads
STATUS_PORT, 8'h04, host port_id for status reads

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high
port_id  input  8  host port address (full 8-bit compare)
write_strobe  input  1  host write qualifier
read_strobe  input  1  host read qualifier
out_port  input  8  host write data (ciphertext)
in_port  output  8  host read data, combinational on port_id
interrupt  output  1  plaintext-available flag to host
interrupt_ack  input  1  host interrupt acknowledge
key_strobe  input  1  one-cycle pad-byte write from key source
key_data  input  8  pad byte
key_request  output  1  high while the key FIFO is not full

Behaviour:
- Reset (sync, active-high):
  - Both FIFOs empty.
  - FSM goes to IDLE and the ct register is cleared.
  - Sticky flags cleared; interrupt=0; key_request=1 on the first cycle after reset.
  - Reset takes priority over every other input on that edge, including any pending ciphertext.
- Key FIFO:
  - Pushes key_data on key_strobe.
  - If full and no pop happens on the same edge, the byte is dropped and sticky key_ovf is set.
  - Push and pop on the same edge are both performed, so the count is unchanged.
- Ciphertext write (write_strobe & port_id==CT_PORT):
  - Accepted only in IDLE: out_port is latched and the FSM goes to HAVE_CT.
  - In HAVE_CT the write is dropped and sticky ct_ovr is set.
- FSM states are IDLE and HAVE_CT.
- In HAVE_CT, on each edge where the key FIFO is non-empty and the output FIFO is not full (a pop on the same edge counts as freeing space):
  - push ct ^ key_head into the output FIFO;
  - pop the key FIFO;
  - go to IDLE.
  - Otherwise stay in HAVE_CT.
- Latency:
  - Ciphertext at edge N with a key present: plaintext at edge N+1.
  - Key arrives later at edge K: plaintext at edge K+1.
  - Back-to-back throughput is one byte per 2 cycles.
- Plaintext read (read_strobe & port_id==PT_PORT):
  - Pops the head if non-empty; ignored if empty.
  - in_port shows the head combinationally while port_id==PT_PORT; 8'h00 if empty.
- Status read (port_id==STATUS_PORT):
  - in_port = {2'b0, ct_ovr, key_ovf, busy(HAVE_CT), key_empty, out_full, out_nonempty}.
  - read_strobe on this port clears ct_ovr and key_ovf at the edge.
  - An overflow event on that same edge wins, so the flag stays set.
- Any other port_id: in_port=8'h00.
- Interrupt:
  - Set on any edge that pushes plaintext.
  - Cleared by interrupt_ack.
  - Push and ack on the same edge: push wins and interrupt stays 1.
  - Not re-asserted by a non-empty FIFO alone.
- key_request = !key_full, driven from registered count (no combinational path from key_strobe).
- Arithmetic: 8-bit XOR, no carries. FIFO pointers wrap modulo depth. Counts are log2(depth)+1 bits wide.

Test Plan:
- Decrypt with key present:
  - Stimulus: reset; key 8'h5A; ciphertext 8'h3C.
  - Response: one edge later out_nonempty=1 and interrupt=1; in_port on PT_PORT = 8'h66; read pops it and status reads 8'h04.
- Ciphertext before key:
  - Stimulus: ciphertext 8'hFF with the key FIFO empty.
  - Response: busy=1 and no push. Key 8'h0F at edge K produces plaintext 8'hF0 at K+1, and busy=0.
- Key overflow:
  - Stimulus: five keys 01..05, no ciphertext.
  - Response: the FIFO holds 01..04 and key_request=0. Status shows key_ovf (bit4) and key_empty=0. After a status read, bit4=0.
- Output full stall:
  - Stimulus: four key/ciphertext pairs with no reads, then a fifth pair.
  - Response: out_full=1 and busy stays 1. One PT read frees space; the fifth plaintext is pushed on that edge, and an ordered drain returns all five bytes.
- Ciphertext overrun and ack race:
  - Stimulus: a second ciphertext write while in HAVE_CT.
  - Response: ct_ovr=1 and the first byte is still decrypted correctly. interrupt_ack on the push edge leaves interrupt=1; a later ack clears it.
- Reset mid-operation:
  - Stimulus: reset while in HAVE_CT with 2 keys and 1 plaintext queued.
  - Response: next cycle interrupt=0, status=8'h04, key_request=1; the pending ciphertext is never output.
